ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares the single RAM port (ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate) among REQS word-access requesters, e.g. instruction and data caches of multiple cores. It sits between the requesters and the RAM model. It serialises accesses one word at a time and returns per-requester wait and load. Coherence is out of scope; the block is a pure resource scheduler.

## Interface
- REQS, 4: number of requesters (2..8); index 0 has highest priority at reset.
- BURST_MAX, 4: max consecutive grants to one requester (used only with RAM_ARB_BURST_EN).
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset; one clock; reset is synchronous and active-low.
- REN  in  REQS  per-requester read request.
- WEN  in  REQS  per-requester write request.
- addr  in  REQS x 32  per-requester word address (word_t).
- store  in  REQS x 32  per-requester write data.
- rwait  out  REQS  per-requester wait; 0 only in the completing cycle of that requester's access.
- load  out  REQS x 32  read data; equals ramload for the owner in its completing cycle, else 0.
- gnt  out  REQS  one-hot current owner, 0 when none.
- ramREN, ramWEN  out  1  RAM strobes.
- ramaddr, ramstore  out  32  RAM address / write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.

## Operation
- Request of requester i: req[i] = REN[i] | WEN[i]; held with stable addr/store until rwait[i]=0.
- Registers: state, owner (index), rr_ptr (index), burst_cnt.
- States: IDLE, GRANT, RELEASE.
- IDLE: if any req, owner <= first i with req[i] searching from rr_ptr upward, wrapping modulo REQS; go GRANT. Else stay.
- GRANT: gnt[owner]=1; ramaddr=addr[owner]; if WEN[owner], ramWEN=1 and ramstore=store[owner], ramREN=0 (write wins when both set); else ramREN=1.
  - ramstate==ACCESS: rwait[owner]=0, load[owner]=ramload if read; go RELEASE.
  - req[owner] dropped before ACCESS: abort, go IDLE, rr_ptr unchanged, no rwait pulse.
  - BUSY, FREE, ERROR: hold, all rwait=1. ERROR is held indefinitely until ACCESS or abort.
- RELEASE: RAM outputs all 0, gnt=0, all rwait=1 (one-cycle gap so owner can update its request).
  - rr_ptr <= (owner+1) mod REQS, burst_cnt <= 0, selection as in IDLE using the new rr_ptr in the same cycle. Next state is GRANT if any req, else IDLE.
- Outputs in IDLE: all RAM outputs 0, gnt=0, rwait all 1, load all 0.
- Reset (nRST=0 at an edge, including mid-GRANT): state=IDLE, owner=0, rr_ptr=0, burst_cnt=0. The in-flight access is dropped with no rwait pulse.

## Timing
- Outputs are combinational from state, owner, and ramstate/ramload; the decision is registered.
- Request first seen in IDLE at cycle 0: ramREN/ramWEN asserted cycle 1.
- Completion is the same cycle ramstate==ACCESS. Minimum latency 1 cycle after grant.
- Back-to-back accesses cost GRANT(n) + RELEASE(1) cycles. No accesses are issued in RELEASE.
- Requester i waits at most REQS-1 other accesses (fair rotation). With burst enabled, the bound is (REQS-1)*BURST_MAX.

## Configuration
- RAM_ARB_BURST_EN defined: in RELEASE, if req[owner] is still set and burst_cnt < BURST_MAX-1, the owner is re-granted, burst_cnt increments, and rr_ptr is unchanged. Otherwise rotation proceeds as normal and burst_cnt clears.
- Undefined: strict one-access-per-grant rotation; BURST_MAX ignored; burst_cnt not implemented.

## Test plan
- Single read: REN[2]=1, addr[2]=0x40, RAM answers ACCESS 2 cycles after ramREN with ramload=0xDEADBEEF. Required: ramaddr=0x40, rwait[2]=0 for exactly that cycle, load[2]=0xDEADBEEF, then RELEASE and IDLE.
- Simultaneous requests: REN[0]=WEN[1]=1 after reset. Required order is 0 then 1. ramWEN=1 with ramstore=store[1] only in 1's GRANT.
- Fairness: all 4 requesters hold requests continuously, RAM always ACCESS. Required grant sequence 0,1,2,3,0,1, with RELEASE cycles between grants and no ram strobe in RELEASE.
- Abort and error: ramstate=ERROR for 5 cycles with REN[1]=1. Required: rwait stays 1, grant held. Then drop REN[1]: IDLE next cycle, rr_ptr unchanged, a later REN[1] is granted first.
- Reset mid-access: assert nRST=0 during GRANT of requester 3 with BUSY. Required: next cycle gnt=0, ramREN=0, rwait all 1, and no rwait pulse to 3.
- With RAM_ARB_BURST_EN, BURST_MAX=4, requesters 0 and 1 hold requests continuously. Required grants are 0,0,0,0,1,1,1,1,0 (without the macro: 0,1,0,1).

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one word-wide RAM port among REQS requesters.
// Optional feature macro: RAM_ARB_BURST_EN (owner re-grant up to BURST_MAX accesses).
module ram_port_arbiter #(
  parameter int unsigned REQS      = 4,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic [REQS-1:0]            REN,
  input  logic [REQS-1:0]            WEN,
  input  logic [REQS-1:0][31:0]      addr,
  input  logic [REQS-1:0][31:0]      store,
  output logic [REQS-1:0]            rwait,
  output logic [REQS-1:0][31:0]      load,
  output logic [REQS-1:0]            gnt,
  output logic                       ramREN,
  output logic                       ramWEN,
  output logic [31:0]                ramaddr,
  output logic [31:0]                ramstore,
  input  logic [31:0]                ramload,
  input  logic [1:0]                 ramstate
);

  localparam int unsigned IW = (REQS > 1) ? $clog2(REQS) : 1;

  if (REQS < 2 || REQS > 8 || BURST_MAX < 1) begin : g_bad_cfg
    $error("ram_port_arbiter: REQS must be 2..8 and BURST_MAX at least 1");
  end

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQS-1:0] req;
  logic [IW:0]     sel_idle, sel_rel;
  logic [IW-1:0]   rot_ptr;
  logic            rotate;

`ifdef RAM_ARB_BURST_EN
  localparam int unsigned BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
`endif

  // Returns {found, index} of the first requester at or after ptr, wrapping.
  function automatic logic [IW:0] pick(input logic [REQS-1:0] r, input logic [IW-1:0] ptr);
    logic [IW:0]  res;
    int unsigned  idx;
    res = '0;
    for (int unsigned k = 0; k < REQS; k++) begin
      idx = (32'(ptr) + k) % REQS;
      if (!res[IW] && r[IW'(idx)]) res = {1'b1, IW'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    req      = REN | WEN;
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    rotate   = 1'b1;
`ifdef RAM_ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif
    gnt      = '0;
    rwait    = '1;
    load     = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    sel_idle = pick(req, rr_ptr_q);
    rot_ptr  = IW'((32'(owner_q) + 1) % REQS);
    sel_rel  = pick(req, rot_ptr);

    case (state_q)
      IDLE: begin
        if (sel_idle[IW]) begin
          owner_d = sel_idle[IW-1:0];
          state_d = GRANT;
`ifdef RAM_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        gnt[owner_q] = 1'b1;
        ramaddr      = addr[owner_q];
        if (WEN[owner_q]) begin
          ramWEN   = 1'b1;
          ramstore = store[owner_q];
        end else begin
          ramREN   = REN[owner_q];
        end
        // A dropped request aborts even if the RAM completes in the same cycle.
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (ramstate == ACCESS) begin
          rwait[owner_q] = 1'b0;
          if (!WEN[owner_q]) load[owner_q] = ramload;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
`ifdef RAM_ARB_BURST_EN
        if (req[owner_q] && (burst_cnt_q < BURST_LAST)) begin
          rotate      = 1'b0;
          burst_cnt_d = burst_cnt_q + 1'b1;
          state_d     = GRANT;
        end
`endif
        if (rotate) begin
          rr_ptr_d = rot_ptr;
`ifdef RAM_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
          if (sel_rel[IW]) begin
            owner_d = sel_rel[IW-1:0];
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
`ifdef RAM_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef RAM_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed self-checking bench for ram_port_arbiter (REQS=4, BURST_MAX=4).
module tb_ram_port_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [3:0]        REN, WEN;
  logic [3:0][31:0]  addr, store;
  logic [3:0]        rwait, gnt;
  logic [3:0][31:0]  load;
  logic              ramREN, ramWEN;
  logic [31:0]       ramaddr, ramstore, ramload;
  logic [1:0]        ramstate;

  int n_checks = 0;
  int n_fails  = 0;

  ram_port_arbiter #(.REQS(4), .BURST_MAX(4)) dut (
    .CLK(CLK), .nRST(nRST), .REN(REN), .WEN(WEN), .addr(addr), .store(store),
    .rwait(rwait), .load(load), .gnt(gnt), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0; REN = '0; WEN = '0; ramstate = FREE; ramload = '0;
    tick(); tick();
    nRST = 1'b1;
  endtask

`ifdef RAM_ARB_BURST_EN
  int exp_seq[$] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
`else
  int exp_seq[$] = '{0, 1, 0, 1};
`endif

  initial begin
    REN = '0; WEN = '0; addr = '0; store = '0; ramload = '0; ramstate = FREE; nRST = 1'b0;

    // Reset state
    do_reset();
    #1;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rwait", rwait, 4'b1111);
    chk("rst_ramren", ramREN, 1'b0);
    chk("rst_ramwen", ramWEN, 1'b0);
    chk("rst_load0", load[0], 32'h0);

    // Single read by requester 2, ACCESS two cycles after ramREN
    REN[2] = 1'b1; addr[2] = 32'h40; ramstate = BUSY; #1;
    chk("rd_c0_ramren", ramREN, 1'b0);
    tick(); #1;
    chk("rd_c1_gnt", gnt, 4'b0100);
    chk("rd_c1_ramren", ramREN, 1'b1);
    chk("rd_c1_ramaddr", ramaddr, 32'h40);
    chk("rd_c1_rwait", rwait, 4'b1111);
    tick(); #1;
    chk("rd_c2_rwait", rwait, 4'b1111);
    tick(); ramstate = ACCESS; ramload = 32'hDEADBEEF; #1;
    chk("rd_c3_rwait", rwait, 4'b1011);
    chk("rd_c3_load2", load[2], 32'hDEADBEEF);
    chk("rd_c3_load0", load[0], 32'h0);
    tick(); REN[2] = 1'b0; ramstate = FREE; ramload = '0; #1;
    chk("rd_rel_gnt", gnt, 4'b0000);
    chk("rd_rel_ramren", ramREN, 1'b0);
    chk("rd_rel_rwait", rwait, 4'b1111);
    tick(); #1;
    chk("rd_idle_gnt", gnt, 4'b0000);

    // Simultaneous read 0 / write 1
    do_reset();
    REN[0] = 1'b1; WEN[1] = 1'b1; addr[0] = 32'h100; addr[1] = 32'h200;
    store[0] = 32'h11111111; store[1] = 32'hCAFEF00D; ramstate = ACCESS; ramload = 32'h5A5A5A5A;
    tick(); #1;
    chk("sim_g0_gnt", gnt, 4'b0001);
    chk("sim_g0_ramren", ramREN, 1'b1);
    chk("sim_g0_ramwen", ramWEN, 1'b0);
    chk("sim_g0_addr", ramaddr, 32'h100);
    chk("sim_g0_rwait", rwait, 4'b1110);
    chk("sim_g0_load", load[0], 32'h5A5A5A5A);
    tick(); REN[0] = 1'b0; #1;
    chk("sim_rel_gnt", gnt, 4'b0000);
    chk("sim_rel_ramwen", ramWEN, 1'b0);
    tick(); #1;
    chk("sim_g1_gnt", gnt, 4'b0010);
    chk("sim_g1_ramwen", ramWEN, 1'b1);
    chk("sim_g1_ramren", ramREN, 1'b0);
    chk("sim_g1_store", ramstore, 32'hCAFEF00D);
    chk("sim_g1_addr", ramaddr, 32'h200);
    chk("sim_g1_rwait", rwait, 4'b1101);
    chk("sim_g1_load", load[1], 32'h0);
    tick(); WEN[1] = 1'b0; #1;
    chk("sim_rel2_ramwen", ramWEN, 1'b0);

    // Fairness: all four requesting, RAM always ready
    do_reset();
    REN = 4'b1111; ramstate = ACCESS; ramload = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      tick(); #1;
      chk("fair_gnt", gnt, 4'b0001 << (i % 4));
      chk("fair_ramren", ramREN, 1'b1);
      chk("fair_load", load[i % 4], 32'h12345678);
      tick(); #1;
      chk("fair_rel_gnt", gnt, 4'b0000);
      chk("fair_rel_ramren", ramREN, 1'b0);
      chk("fair_rel_ramwen", ramWEN, 1'b0);
    end
    REN = '0;

    // ERROR held, then abort; rr_ptr must stay at 0
    do_reset();
    REN[1] = 1'b1; addr[1] = 32'h80; ramstate = ERROR;
    tick(); #1;
    for (int i = 0; i < 5; i++) begin
      chk("err_gnt", gnt, 4'b0010);
      chk("err_rwait", rwait, 4'b1111);
      tick(); #1;
    end
    REN[1] = 1'b0; #1;
    chk("abort_rwait", rwait, 4'b1111);
    tick(); #1;
    chk("abort_idle_gnt", gnt, 4'b0000);
    REN[1] = 1'b1; REN[2] = 1'b1; ramstate = ACCESS;
    tick(); #1;
    chk("abort_regrant", gnt, 4'b0010);

    // Reset in the middle of requester 3's access
    do_reset();
    REN[3] = 1'b1; ramstate = BUSY;
    tick(); #1;
    chk("mid_gnt", gnt, 4'b1000);
    chk("mid_ramren", ramREN, 1'b1);
    nRST = 1'b0; ramstate = ACCESS;
    tick(); #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_ramren", ramREN, 1'b0);
    chk("mid_rst_rwait", rwait, 4'b1111);
    REN[3] = 1'b0; nRST = 1'b1;

    // Two persistent requesters: rotation (or bursts when enabled)
    do_reset();
    REN = 4'b0011; ramstate = ACCESS;
    foreach (exp_seq[i]) begin
      tick(); #1;
      chk("burst_gnt", gnt, 4'b0001 << exp_seq[i]);
      tick(); #1;
      chk("burst_rel_gnt", gnt, 4'b0000);
    end
    REN = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
